// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmit sequencer.
package morse_pkg;
  localparam int PAT_W     = 22;
  localparam int LEN_W     = 5;
  localparam int MAX_CHARS = 12;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pattern;
  } char_t;

  // Lengths beyond the pattern width would index non-existent units.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
  endfunction
endpackage

// File: rtl/morse_tx_sequencer_if.sv
// Character write channel. valid/ready: a character transfers on a rising
// edge where char_valid and char_ready are both high; pattern/len must be
// stable while char_valid is high.
interface morse_tx_sequencer_if;
  import morse_pkg::*;
  logic [PAT_W-1:0] char_pattern;
  logic [LEN_W-1:0] char_len;
  logic             char_valid;
  logic             char_ready;

  modport master (output char_pattern, output char_len, output char_valid, input char_ready);
  modport slave  (input char_pattern, input char_len, input char_valid, output char_ready);
endinterface

// File: rtl/morse_unit_timer.sv
// Unit-rate prescaler: unit_tick marks the last clock of each Morse unit.
module morse_unit_timer #(
  parameter int DIV_UNIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic unit_tick
);
  localparam int CW = (DIV_UNIT > 1) ? $clog2(DIV_UNIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_UNIT - 1);

  logic [CW-1:0] cnt;

  assign unit_tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (unit_tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/morse_tx_sequencer.sv
// Buffers encoded Morse characters and serialises them on salida, one unit
// per DIV_UNIT clocks, with GAP_UNITS zero units after each character.
module morse_tx_sequencer
  import morse_pkg::*;
#(
  parameter int MAX_CHARS = morse_pkg::MAX_CHARS,
  parameter int DIV_UNIT  = 4,
  parameter int GAP_UNITS = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  morse_tx_sequencer_if.slave   bus,
  input  logic                  clear,
  input  logic                  Start,
  output logic                  salida,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            count,
  output state_t                state
);
  localparam logic [3:0] MAX_C = 4'(MAX_CHARS);
  localparam int GW = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_UNITS - 1);

  state_t           state_next;
  char_t            slots [MAX_CHARS];
  char_t            cur;
  logic [3:0]       idx;
  logic [3:0]       idx_inc;
  logic [LEN_W-1:0] bit_idx;
  logic [GW-1:0]    gap_cnt;
  logic             tick;
  logic             start_go;
  logic             wr;

  assign cur            = slots[idx];
  assign idx_inc        = idx + 4'd1;
  assign start_go       = Start && (count != 4'd0);
  assign bus.char_ready = (state == IDLE) && (count < MAX_C);
  // clear outranks Start, which outranks a write, when they coincide.
  assign wr             = bus.char_valid && bus.char_ready && !clear && !start_go;
  assign busy           = (state == SEND) || (state == GAP);
  assign done           = (state == DONE);
  assign salida         = (state == SEND) && cur.pattern[bit_idx];

  // Restarting on every state change keeps each state's first unit full length.
  morse_unit_timer #(.DIV_UNIT(DIV_UNIT)) u_timer (
    .clk       (CLK),
    .rst       (RST),
    .clear     (state_next != state),
    .unit_tick (tick)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!clear && start_go) state_next = (slots[0].len == '0) ? GAP : SEND;
      SEND: if (tick && (bit_idx == cur.len - 1'b1)) state_next = GAP;
      GAP: begin
        if (tick && (gap_cnt == GAP_LAST)) begin
          if (idx == count - 4'd1) state_next = DONE;
          else state_next = (slots[idx_inc].len == '0) ? GAP : SEND;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      count   <= '0;
      idx     <= '0;
      bit_idx <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          idx     <= '0;
          bit_idx <= '0;
          gap_cnt <= '0;
          if (clear) count <= '0;
          else if (wr) count <= count + 4'd1;
        end
        SEND: if (tick) bit_idx <= (state_next == SEND) ? bit_idx + 1'b1 : '0;
        GAP: begin
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              idx     <= idx_inc;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          count <= '0;
          idx   <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) slots[count] <= '{len: sat_len(bus.char_len), pattern: bus.char_pattern};
  end
endmodule
